fifo_drain_fsm: RTL and testbench
=================================

# fifo_drain_fsm

Consumer-side controller for the 8-bit byte FIFO: the read-end counterpart of the fill-level-driven writer FSM. It waits until the FIFO holds enough words, drains it in a burst, and checks every word returned against a fixed expected pattern. It keeps word, burst and error statistics for the status path. It sits between the FIFO read port and the status/LED logic.

## Interface
- `WORDS_W`, 4: width of `fifo_words`, the FIFO occupancy count.
- `START_LEVEL`, 4: occupancy at or above which a drain burst starts.
- `EXPECTED`, 8'hAA: pattern every read word must match.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `en`  in  1  drain enable; when low, no new burst starts and an active burst stops.
- `clear`  in  1  synchronous clear of the statistics counters and `err_flag`.
- `fifo_words`  in  WORDS_W  current FIFO occupancy.
- `fifo_rd_data`  in  8  FIFO read data, valid 1 cycle after `rd_en`.
- `rd_en`  out  1  FIFO read strobe; combinational.
- `busy`  out  1  high while in READ; registered.
- `word_cnt`  out  CNT_W  words received; wraps.
- `err_cnt`  out  CNT_W  mismatching words; saturates at all-ones.
- `burst_cnt`  out  CNT_W  number of WAIT->READ transitions; wraps.
- `err_flag`  out  1  sticky; set by any mismatch.

## Operation
- The FSM has two states:
  - WAIT: `rd_en`=0.
  - READ: `rd_en` = `en` && (`fifo_words` != 0). The block never reads an empty FIFO.
- Transitions:
  - WAIT->READ when `en` && `fifo_words` >= START_LEVEL. This increments `burst_cnt`.
  - READ->WAIT when !`en`, or `fifo_words` <= 1. At `fifo_words`==1 the last word is read in that same cycle.
  - Any other state encoding goes to WAIT.
- Read pipeline: register `rd_vld` <= `rd_en`. When `rd_vld`=1, `fifo_rd_data` is sampled:
  - `word_cnt` += 1.
  - If `fifo_rd_data` != EXPECTED: `err_cnt` += 1 (saturating) and `err_flag` <= 1.
- The `rd_vld` capture still completes after the FSM returns to WAIT. The last word of a burst is always checked.
- `clear`=1 zeroes `word_cnt`, `err_cnt`, `burst_cnt` and `err_flag`. It has priority over a same-cycle increment, so that word or burst is not counted. `clear` does not affect the state or `rd_vld`.
- Arithmetic: `fifo_words` compares are unsigned. Width-extend START_LEVEL to WORDS_W. START_LEVEL must be ≥ 1 and ≤ 2**WORDS_W-1.

## Timing
- Reset values: state WAIT, `rd_en` 0, `rd_vld` 0, `busy` 0, all counters 0, `err_flag` 0.
- Reset mid-burst: `rd_en` drops in the cycle after reset is sampled. A pending `rd_vld` word is discarded.
- Latency:
  - `fifo_words` reaching START_LEVEL at edge N gives state READ and `rd_en`=1 from edge N+1.
  - Data appears at N+2; `word_cnt` updates at edge N+3.
- `busy` equals the state and is registered, so it matches `rd_en` except when `en` or `fifo_words` gates `rd_en` low.
- `en` falling in READ: `rd_en` drops in the same cycle (combinational) and the state goes to WAIT at the next edge.
- Concurrent FIFO writes during READ are allowed. The burst continues while `fifo_words` > 1.

## Structure
- Shared package holds:
  - the state encoding localparams (WAIT=1'b0, READ=1'b1), common with the writer FSM;
  - the default pattern constant 8'hAA, shared with the writer's data source.
- One sub-module is natural: `fifo_rd_checker`. It holds `rd_vld`, the compare, `word_cnt`, `err_cnt` and `err_flag`, with `clear` handling.
- The top level holds the FSM, the `rd_en` logic and `burst_cnt`.

## Test plan
- Fill the FIFO to 4 words of 8'hAA with `en`=1 → `rd_en` asserts 1 cycle after `fifo_words`=4 and stays high 4 cycles. Then: state WAIT, `word_cnt`=4, `burst_cnt`=1, `err_cnt`=0.
- Hold occupancy at 3 → no read ever, `busy`=0. Raise to 4 → burst starts.
- Drain 4 words containing AA,55,AA,00 → `err_cnt`=2, `err_flag`=1, `word_cnt`=4. Pulse `clear` → all zero.
- Writer adds words during the burst, holding occupancy at ≥2 for 10 cycles → `rd_en` continuously high. It never reads when `fifo_words`=0.
- Drop `en` mid-burst after 2 reads → `rd_en` low in the same cycle and state WAIT next cycle. The second word is still checked; `word_cnt`=2.
- Assert `rst_n`=0 mid-burst, and assert `clear` in the same cycle as `rd_vld` → all outputs at reset values after 1 edge. With `clear`, `word_cnt` stays 0.

Source files
------------

// File: rtl/fifo_drain_fsm_pkg.sv
// Shared constants for the byte-FIFO writer/drain controllers.
//   ST_WAIT / ST_READ : state encoding shared with the writer FSM
//   PATTERN_DEFAULT   : data pattern produced by the writer's source
package fifo_drain_fsm_pkg;

  localparam int unsigned STATE_W = 1;
  localparam int unsigned DATA_W  = 8;

  localparam logic [STATE_W-1:0] ST_WAIT = 1'b0;
  localparam logic [STATE_W-1:0] ST_READ = 1'b1;

  localparam logic [DATA_W-1:0] PATTERN_DEFAULT = 8'hAA;

endpackage

// File: rtl/fifo_drain_fsm_if.sv
// FIFO read-port bundle between the drain controller and the byte FIFO.
//   fifo_words   : FIFO occupancy (FIFO -> controller)
//   fifo_rd_data : read data, valid one cycle after rd_en (FIFO -> controller)
//   rd_en        : read strobe (controller -> FIFO)
interface fifo_drain_fsm_if #(
  parameter int unsigned WORDS_W = 4
);
  import fifo_drain_fsm_pkg::*;

  logic [WORDS_W-1:0] fifo_words;
  logic [DATA_W-1:0]  fifo_rd_data;
  logic               rd_en;

  modport master (output rd_en, input fifo_words, input fifo_rd_data);
  modport slave  (input rd_en, output fifo_words, output fifo_rd_data);

endinterface

// File: rtl/fifo_rd_checker.sv
// Read-data checker: delays the read strobe by one cycle, then counts each
// returned word and flags words that differ from the expected pattern.
//   clk, rst_n  : clock, synchronous active-low reset
//   rd_en_i     : FIFO read strobe issued this cycle
//   clear_i     : zero counters and sticky flag (wins over increments)
//   rd_data_i   : FIFO read data
//   word_cnt_o  : words received (wraps)
//   err_cnt_o   : mismatching words (saturates)
//   err_flag_o  : sticky mismatch flag
module fifo_rd_checker
  import fifo_drain_fsm_pkg::*;
#(
  parameter int unsigned       CNT_W    = 16,
  parameter logic [DATA_W-1:0] EXPECTED = PATTERN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              err_flag_o
);

  logic             rd_vld_q;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;

  // Capture and compare the word returned for last cycle's read
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (clear_i) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (rd_vld_q) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (rd_data_i != EXPECTED) begin
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
        err_flag_d = 1'b1;
      end
    end
  end

  // rd_vld is deliberately untouched by clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      rd_vld_q   <= rd_en_i;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_flag_o = err_flag_q;

endmodule

// File: rtl/fifo_drain_fsm.sv
// Drain controller for the byte FIFO: waits for START_LEVEL words, reads the
// FIFO in a burst until it is down to its last word, checks every word.
//   clk, rst_n  : clock, synchronous active-low reset
//   en_i        : drain enable (stops an active burst when low)
//   clear_i     : clear statistics and error flag
//   fifo        : FIFO read port (master side; rd_en is combinational)
//   busy_o      : high while bursting
//   word_cnt_o, err_cnt_o, burst_cnt_o, err_flag_o : statistics
module fifo_drain_fsm
  import fifo_drain_fsm_pkg::*;
#(
  parameter int unsigned       WORDS_W     = 4,
  parameter int unsigned       START_LEVEL = 4,
  parameter logic [DATA_W-1:0] EXPECTED    = PATTERN_DEFAULT,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clear_i,
  fifo_drain_fsm_if.master fifo,
  output logic             busy_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] burst_cnt_o,
  output logic             err_flag_o
);

  localparam logic [WORDS_W-1:0] START_LVL = WORDS_W'(START_LEVEL);
  localparam logic [WORDS_W-1:0] ONE_WORD  = WORDS_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic               rd_en_c;
  logic               burst_start_c;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  // Next state and read strobe; the last word is read in the exit cycle
  always_comb begin
    state_d       = ST_WAIT;
    rd_en_c       = 1'b0;
    burst_start_c = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (en_i && (fifo.fifo_words >= START_LVL)) begin
          state_d       = ST_READ;
          burst_start_c = 1'b1;
        end
      end
      ST_READ: begin
        rd_en_c = en_i && (fifo.fifo_words != '0);
        if (en_i && (fifo.fifo_words > ONE_WORD)) state_d = ST_READ;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Burst counter, clear wins over a same-cycle start
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (clear_i)            burst_cnt_d = '0;
    else if (burst_start_c) burst_cnt_d = burst_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign fifo.rd_en  = rd_en_c;
  assign busy_o      = (state_q == ST_READ);
  assign burst_cnt_o = burst_cnt_q;

  fifo_rd_checker #(
    .CNT_W    (CNT_W),
    .EXPECTED (EXPECTED)
  ) u_rd_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_i    (rd_en_c),
    .clear_i    (clear_i),
    .rd_data_i  (fifo.fifo_rd_data),
    .word_cnt_o (word_cnt_o),
    .err_cnt_o  (err_cnt_o),
    .err_flag_o (err_flag_o)
  );

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// Bench for fifo_drain_fsm: a queue-based FIFO drives the read port, a
// behavioural model predicts every output each cycle.
module tb_fifo_drain_fsm;
  import fifo_drain_fsm_pkg::*;

  logic        clk;
  logic        rst_n, en, clear;
  logic        busy, err_flag;
  logic [15:0] word_cnt, err_cnt, burst_cnt;

  fifo_drain_fsm_if #(.WORDS_W(4)) fif ();

  fifo_drain_fsm #(
    .WORDS_W(4), .START_LEVEL(4), .EXPECTED(8'hAA), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .clear_i     (clear),
    .fifo        (fif),
    .busy_o      (busy),
    .word_cnt_o  (word_cnt),
    .err_cnt_o   (err_cnt),
    .burst_cnt_o (burst_cnt),
    .err_flag_o  (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // stimulus controls, applied at the falling edge
  bit rst_v, en_v, clear_v, rnd_mode;
  logic [7:0] wq[$];   // words the writer will push, one per cycle
  logic [7:0] fq[$];   // FIFO contents
  logic [7:0] rdata;   // FIFO read-data register
  int rd_total;

  // behavioural model
  bit          m_busy, m_vld, m_flag;
  logic [15:0] m_word, m_err, m_burst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against model, advance FIFO and model
  task automatic cycle();
    logic [3:0] words;
    logic [7:0] cur_data;
    logic       exp_rd, act_rd;
    @(negedge clk);
    words    = 4'(fq.size());
    cur_data = rdata;
    rst_n = rst_v; en = en_v; clear = clear_v;
    fif.fifo_words   = words;
    fif.fifo_rd_data = cur_data;
    exp_rd = m_busy && en_v && (words != 4'd0);
    #1;
    act_rd = fif.rd_en;
    chk("rd_en",     32'(act_rd),    32'(exp_rd));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("word_cnt",  32'(word_cnt),  32'(m_word));
    chk("err_cnt",   32'(err_cnt),   32'(m_err));
    chk("burst_cnt", 32'(burst_cnt), 32'(m_burst));
    chk("err_flag",  32'(err_flag),  32'(m_flag));
    @(posedge clk);
    // model
    if (!rst_v) begin
      m_busy = 0; m_vld = 0; m_flag = 0;
      m_word = '0; m_err = '0; m_burst = '0;
    end else begin
      if (clear_v) begin
        m_word = '0; m_err = '0; m_burst = '0; m_flag = 0;
      end else begin
        if (m_vld) begin
          m_word = m_word + 16'd1;
          if (cur_data != 8'hAA) begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            m_flag = 1;
          end
        end
        if (!m_busy && en_v && words >= 4'd4) m_burst = m_burst + 16'd1;
      end
      if (!m_busy) m_busy = en_v && (words >= 4'd4);
      else         m_busy = en_v && (words > 4'd1);
      m_vld = exp_rd;
    end
    // FIFO environment
    if (!rst_v) begin
      fq.delete();
      rdata = 8'h00;
    end else begin
      if (act_rd) begin
        chk("nonempty_read", 32'(fq.size() > 0), 32'd1);
        if (fq.size() > 0) rdata = fq.pop_front();
        rd_total++;
      end
      if (wq.size() > 0 && fq.size() < 15) fq.push_back(wq.pop_front());
      else if (rnd_mode && fq.size() < 15 && $urandom_range(0, 99) < 55)
        fq.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hAA);
    end
  endtask

  task automatic run_drain(input int max_cycles);
    int n;
    n = 0;
    while ((fq.size() > 0 || wq.size() > 0 || m_busy || m_vld) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: still active after %0d cycles", max_cycles);
    end
  endtask

  task automatic pulse_clear();
    clear_v = 1; cycle(); clear_v = 0;
  endtask

  initial begin
    int n;
    rst_n = 0; en = 0; clear = 0;
    fif.fifo_words = '0; fif.fifo_rd_data = '0;
    rst_v = 0; en_v = 1; clear_v = 0; rnd_mode = 0;
    rdata = 8'h00; rd_total = 0;
    m_busy = 0; m_vld = 0; m_flag = 0;
    m_word = '0; m_err = '0; m_burst = '0;

    // reset
    repeat (3) cycle();
    rst_v = 1;
    #2;
    chk("reset_rd_en", 32'(fif.rd_en), 32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_words", 32'(word_cnt),  32'd0);

    // basic 4-word burst
    repeat (4) wq.push_back(8'hAA);
    rd_total = 0;
    run_drain(100);
    #2;
    chk("p1_word_cnt",  32'(word_cnt),  32'd4);
    chk("p1_burst_cnt", 32'(burst_cnt), 32'd1);
    chk("p1_err_cnt",   32'(err_cnt),   32'd0);
    chk("p1_busy",      32'(busy),      32'd0);
    chk("p1_reads",     32'(rd_total),  32'd4);

    // occupancy 3 never starts a burst, the 4th word does
    repeat (3) wq.push_back(8'hAA);
    rd_total = 0;
    repeat (12) cycle();
    #2;
    chk("p2_no_reads", 32'(rd_total), 32'd0);
    chk("p2_busy",     32'(busy),     32'd0);
    wq.push_back(8'hAA);
    run_drain(100);
    #2;
    chk("p2_reads",     32'(rd_total),  32'd4);
    chk("p2_word_cnt",  32'(word_cnt),  32'd8);
    chk("p2_burst_cnt", 32'(burst_cnt), 32'd2);

    // mismatching words, then clear
    pulse_clear();
    wq.push_back(8'hAA); wq.push_back(8'h55); wq.push_back(8'hAA); wq.push_back(8'h00);
    run_drain(100);
    #2;
    chk("p3_err_cnt",  32'(err_cnt),  32'd2);
    chk("p3_err_flag", 32'(err_flag), 32'd1);
    chk("p3_word_cnt", 32'(word_cnt), 32'd4);
    pulse_clear();
    #2;
    chk("p3_clr_word",  32'(word_cnt),  32'd0);
    chk("p3_clr_err",   32'(err_cnt),   32'd0);
    chk("p3_clr_burst", 32'(burst_cnt), 32'd0);
    chk("p3_clr_flag",  32'(err_flag),  32'd0);

    // writer keeps feeding during the burst: one continuous burst of 16 reads
    repeat (16) wq.push_back(8'hAA);
    rd_total = 0;
    run_drain(200);
    #2;
    chk("p4_reads",     32'(rd_total),  32'd16);
    chk("p4_burst_cnt", 32'(burst_cnt), 32'd1);

    // en dropped after two reads
    repeat (4) wq.push_back(8'hAA);
    rd_total = 0;
    n = 0;
    while (rd_total < 2 && n < 50) begin cycle(); n++; end
    chk("p5_two_reads", 32'(rd_total), 32'd2);
    en_v = 0;
    cycle();
    #2;
    chk("p5_busy_after", 32'(busy), 32'd0);
    repeat (3) cycle();
    #2;
    chk("p5_word_cnt", 32'(word_cnt), 32'd18);
    chk("p5_reads",    32'(rd_total), 32'd2);
    en_v = 1;
    wq.push_back(8'hAA); wq.push_back(8'hAA);
    run_drain(100);
    #2;
    chk("p5_word_end", 32'(word_cnt), 32'd22);

    // reset mid-burst together with clear while a word is pending
    pulse_clear();
    repeat (4) wq.push_back(8'hAA);
    n = 0;
    while (!m_vld && n < 50) begin cycle(); n++; end
    chk("p6_pending", 32'(m_vld), 32'd1);
    rst_v = 0; clear_v = 1;
    cycle();
    rst_v = 1; clear_v = 0;
    #2;
    chk("p6_rd_en",    32'(fif.rd_en), 32'd0);
    chk("p6_busy",     32'(busy),      32'd0);
    chk("p6_word_cnt", 32'(word_cnt),  32'd0);
    chk("p6_burst",    32'(burst_cnt), 32'd0);
    chk("p6_flag",     32'(err_flag),  32'd0);

    // randomized traffic
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      en_v    = ($urandom_range(0, 15) != 0);
      clear_v = ($urandom_range(0, 63) == 0);
      rst_v   = ($urandom_range(0, 255) != 0);
      cycle();
    end
    rnd_mode = 0; en_v = 1; clear_v = 0; rst_v = 1;
    run_drain(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
